// File: rtl/pipeline_token_source.sv
// pipeline_token_source: dual-lane token generator for the two parallel
// datapath pipelines. Emits lockstep, deterministic token streams in bursts
// separated by idle gaps, honours the global stall, and raises done once the
// programmed number of tokens per lane has been accepted.
//
// Handshake: a token is accepted on a rising clk edge where in_valid_* = 1
// and stall = 0. While stall = 1 in RUN or GAP nothing in the block moves, so
// the presented token stays on the bus until it is taken; both lanes always
// share the same valid and are accepted together.
module pipeline_token_source #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    BURST_LEN  = 4,
    parameter int                    GAP_LEN    = 1,
    parameter logic [DATA_WIDTH-1:0] SEED_1     = '0,
    parameter logic [DATA_WIDTH-1:0] SEED_2     = DATA_WIDTH'(1000),
    parameter logic [DATA_WIDTH-1:0] STEP_2     = DATA_WIDTH'(2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_tokens,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] in_data_1,
    output logic                  in_valid_1,
    output logic [DATA_WIDTH-1:0] in_data_2,
    output logic                  in_valid_2,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  tokens_sent,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit            HAS_GAP    = (GAP_LEN > 0);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] target;
    logic [BW-1:0]        burst_cnt;
    logic [GW-1:0]        gap_cnt;
    logic [CNT_WIDTH-1:0] sent_next;
    logic                 accept;

    assign sent_next = tokens_sent + CNT_WIDTH'(1);
    assign accept    = (state == ST_RUN) && !stall;

    // Outputs decode directly from registered state, so they are glitch-free.
    assign in_valid_1 = (state == ST_RUN);
    assign in_valid_2 = (state == ST_RUN);
    assign busy       = (state == ST_RUN) || (state == ST_GAP);
    assign done       = (state == ST_DONE);
    assign state_dbg  = state;

    // Main FSM with token data, counters and the latched run length.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            in_data_1   <= SEED_1;
            in_data_2   <= SEED_2;
            tokens_sent <= '0;
            target      <= '0;
            burst_cnt   <= '0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                // Start is honoured here even under stall; stall only freezes a run.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        in_data_1   <= SEED_1;
                        in_data_2   <= SEED_2;
                        tokens_sent <= '0;
                        burst_cnt   <= '0;
                        gap_cnt     <= '0;
                        target      <= num_tokens;
                        state       <= (num_tokens == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        tokens_sent <= sent_next;
                        in_data_1   <= in_data_1 + DATA_WIDTH'(1);
                        in_data_2   <= in_data_2 + STEP_2;
                        // Finishing the run outranks ending the burst.
                        if (sent_next == target) begin
                            state <= ST_DONE;
                        end else if (burst_cnt == BURST_LAST) begin
                            burst_cnt <= '0;
                            if (HAS_GAP) begin
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!stall) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            state   <= ST_RUN;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pipeline_token_source.md
Name: pipeline_token_source

Overview:
- Dual-lane stimulus generator feeding the two parallel datapath pipelines from their input end.
- It is the transmit-side counterpart to the pipeline output monitors.
- Emits deterministic, lockstep token streams in bursts separated by gaps, and honours the global stall.
- Counts accepted tokens and raises done after a programmed total, so downstream checkers can predict every value.

Parameters:
- DATA_WIDTH, 32, width of each lane's data word.
- CNT_WIDTH, 16, width of token counters and of num_tokens.
- BURST_LEN, 4, tokens issued per burst (>=1).
- GAP_LEN, 1, idle cycles between bursts (0 = no gap state).
- SEED_1, 0, first data value on lane 1.
- SEED_2, 1000, first data value on lane 2.
- STEP_2, 2, per-token increment on lane 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse in IDLE or DONE begins a run; ignored otherwise.
- num_tokens  in  CNT_WIDTH  tokens per lane for the run; sampled on start; 0 = go straight to DONE.
- stall  in  1  global stall; freezes the block when high.
- in_data_1  out  DATA_WIDTH  lane-1 token to pipeline 1.
- in_valid_1  out  1  lane-1 token valid.
- in_data_2  out  DATA_WIDTH  lane-2 token to pipeline 2.
- in_valid_2  out  1  lane-2 token valid.
- busy  out  1  high in RUN or GAP.
- done  out  1  high in DONE until next start or reset.
- tokens_sent  out  CNT_WIDTH  tokens accepted per lane this run.

Behaviour:
- Reset (sync, active-high, dominates all inputs): state=IDLE; in_data_1=SEED_1; in_data_2=SEED_2; in_valid_*=0; busy=0; done=0; tokens_sent=0; burst and gap counters=0.
- Accept: a token is accepted on a rising edge where in_valid_* =1 and stall=0. Both lanes always carry identical valid, so both accept together.
- Data rule, k-th accepted token (k from 0):
  - lane 1 = SEED_1 + k, modulo 2^DATA_WIDTH (wraps silently).
  - lane 2 = SEED_2 + STEP_2*k, modulo 2^DATA_WIDTH (wraps silently).
- Stall: while stall=1, the FSM, all counters, in_data_* and in_valid_* hold their values. No token is lost or duplicated. The start pulse is still honoured in IDLE and DONE (stall gates only RUN and GAP).
- FSM states:
  - IDLE: outputs invalid. On start with num_tokens>0: latch num_tokens, reset data to seeds, clear tokens_sent, go to RUN. in_valid rises the cycle after start (1-cycle start latency).
  - IDLE, start with num_tokens=0: go directly to DONE, with done=1 next cycle.
  - RUN: in_valid=1. On each accept:
    - tokens_sent+1; data advances; burst counter+1.
    - If tokens_sent reaches num_tokens: go to DONE with in_valid=0 next cycle. This takes priority over the burst-end rule.
    - Else if burst counter reaches BURST_LEN and GAP_LEN>0: clear burst counter, go to GAP with in_valid=0.
    - Else stay in RUN, which gives back-to-back tokens.
  - GAP: in_valid=0 for exactly GAP_LEN non-stalled cycles, then back to RUN.
  - DONE: done=1, in_valid=0, tokens_sent holds its final value. start re-arms as from IDLE, and done clears on the same edge.
- Rules by state and event:
  - start in RUN or GAP is ignored.
  - num_tokens changes after start are ignored.
  - tokens_sent never exceeds num_tokens.
  - Reset mid-run aborts immediately, with no further valid tokens.
  - busy = (state==RUN || state==GAP), registered.

Test Plan:
1. Reset, start with num_tokens=10, stall=0, BURST_LEN=4, GAP_LEN=1:
   - lane 1 emits 0..9 and lane 2 emits 1000,1002,...,1018.
   - Valid pattern is 4 on, 1 off, 4 on, 1 off, 2 on.
   - done=1 on the cycle after the 10th accept; tokens_sent=10.
2. Stall high for 3 cycles while token 5 (data 5/1010) is presented:
   - outputs hold 5/1010 for all stalled cycles.
   - The sequence then resumes at 6/1012 with no gap and no duplicate; total accepted stays 10.
3. start with num_tokens=0:
   - done=1 one cycle later, in_valid never asserts, tokens_sent=0.
4. SEED_1=32'hFFFFFFFE, num_tokens=4:
   - lane 1 emits FFFFFFFE, FFFFFFFF, 0, 1 (wrap), with no error or stall.
5. Assert reset after 3 accepted tokens mid-burst:
   - next cycle in_valid=0, state IDLE, data back to seeds.
   - A fresh start restarts from SEED_1/SEED_2.
6. Pulse start during RUN, then again in DONE:
   - the first pulse is ignored, with no restart and no count change.
   - The second pulse clears done and restarts from the seeds.
